// File: rtl/axi4_mem_pkg.sv
// Shared definitions for the strobed memory bank.
//   DEF_DATA_WIDTH   : default bank data width
//   STRB_WIDTH       : byte strobes for the default data width
//   MAX_READ_LATENCY : deepest supported read pipeline
//   mem_rsp_t        : response record {is_write, err, rdata} at the default width
//   strb_to_mask()   : expands one strobe bit to its 8-bit byte-lane mask
package axi4_mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 32;
    localparam int unsigned STRB_WIDTH       = DEF_DATA_WIDTH / 8;
    localparam int unsigned MAX_READ_LATENCY = 4;

    typedef struct packed {
        logic                      is_write;
        logic                      err;
        logic [DEF_DATA_WIDTH-1:0] rdata;
    } mem_rsp_t;

    // Applied once per lane so the full mask scales with any DATA_WIDTH.
    function automatic logic [7:0] strb_to_mask(input logic strb);
        return {8{strb}};
    endfunction

endpackage

// File: rtl/axi4_mem_pipe_stage.sv
// One valid + payload register of the read response pipeline.
//   clk       : clock, posedge
//   rst_n     : synchronous reset, active high; clears valid and payload
//   hold      : freeze the stage (downstream stall)
//   in_valid  : upstream valid
//   in_data   : upstream payload
//   out_valid : registered valid
//   out_data  : registered payload
module axi4_mem_pipe_stage #(
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!hold) begin
            valid_d = in_valid;
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/axi4_strb_mem_bank.sv
// Single-port memory bank with a valid/ready request channel, byte write strobes,
// a READ_LATENCY-deep response pipeline and one in-order response per request.
//   clk          : clock, posedge
//   rst_n        : synchronous reset, ACTIVE HIGH despite the name
//   req_valid    : request present
//   req_ready    : request can be accepted this cycle
//   req_we       : 1 = write, 0 = read
//   req_addr     : word address
//   req_wdata    : write data
//   req_wstrb    : byte enables
//   rsp_valid    : response present
//   rsp_ready    : consumer takes the response
//   rsp_is_write : response belongs to a write
//   rsp_err      : request address was >= DEPTH
//   rsp_rdata    : read data; 0 for writes and errors
module axi4_strb_mem_bank
    import axi4_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_is_write,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata
);

    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam int unsigned PayW  = DATA_WIDTH + 2;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DepthLimit = (ADDR_WIDTH + 1)'(DEPTH);

    initial begin
        if (DATA_WIDTH % 8 != 0) begin
            $fatal(1, "axi4_strb_mem_bank: DATA_WIDTH must be a multiple of 8");
        end
        if (longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin
            $fatal(1, "axi4_strb_mem_bank: DEPTH exceeds 2**ADDR_WIDTH");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin
            $fatal(1, "axi4_strb_mem_bank: READ_LATENCY out of range 1..4");
        end
    end

    logic                  stall;
    logic                  accept;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rsp_word;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  s1_valid_d, s1_valid_q;
    logic [PayW-1:0]       s1_data_d, s1_data_q;

    logic                  stg_valid [READ_LATENCY];
    logic [PayW-1:0]       stg_data  [READ_LATENCY];

    for (genvar b = 0; b < StrbW; b++) begin : g_mask
        assign wmask[8*b +: 8] = strb_to_mask(req_wstrb[b]);
    end

    always_comb begin
        stall     = rsp_valid && !rsp_ready;
        req_ready = !stall && !rst_n;
        accept    = req_valid && req_ready;
        in_range  = {1'b0, req_addr} < DepthLimit;
        // Out-of-range addresses never touch the array.
        rd_word   = in_range ? mem_q[req_addr] : '0;
        wr_word   = (rd_word & ~wmask) | (req_wdata & wmask);
        rsp_word  = (req_we || !in_range) ? '0 : rd_word;
    end

    // Write lands at the accept edge, so a read accepted next cycle sees it.
    always_ff @(posedge clk) begin
        if (accept && req_we && in_range) begin
            mem_q[req_addr] <= wr_word;
        end
    end

    // Stage 1 samples the array; bubbles carry an all-zero payload.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (!stall) begin
            s1_valid_d = accept;
            s1_data_d  = accept ? {req_we, !in_range, rsp_word} : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    assign stg_valid[0] = s1_valid_q;
    assign stg_data[0]  = s1_data_q;

    for (genvar i = 1; i < READ_LATENCY; i++) begin : g_stage
        axi4_mem_pipe_stage #(
            .WIDTH (PayW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .hold      (stall),
            .in_valid  (stg_valid[i-1]),
            .in_data   (stg_data[i-1]),
            .out_valid (stg_valid[i]),
            .out_data  (stg_data[i])
        );
    end

    assign rsp_valid                          = stg_valid[READ_LATENCY-1];
    assign {rsp_is_write, rsp_err, rsp_rdata} = stg_data[READ_LATENCY-1];

endmodule

// File: tb/tb_axi4_strb_mem_bank.sv
module tb_axi4_strb_mem_bank;
    import axi4_mem_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1000;
    localparam int unsigned RL    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_wstrb;
    logic          rsp_valid, rsp_ready, rsp_is_write, rsp_err;
    logic [DW-1:0] rsp_rdata;

    always #5 clk = ~clk;

    axi4_strb_mem_bank #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (RL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_is_write (rsp_is_write),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        mem_rsp_t rsp;
        int       acc_cyc;
        int       stall_at;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    int            cyc       = 0;
    int            stall_cnt = 0;
    bit            head_seen = 0;
    bit            hold_pend = 0;
    logic [DW+2:0] held_out;

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
    end

    initial begin
        exp_t          e;
        exp_t          h;
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                check("reset_req_ready", 64'(req_ready), 64'(0));
                exp_q.delete();
                head_seen = 0;
                hold_pend = 0;
            end else begin
                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_rsp", 64'(rsp_valid), 64'(0));
                    end else begin
                        h = exp_q[0];
                        if (!head_seen) begin
                            check("latency", 64'(cyc - h.acc_cyc),
                                  64'(int'(RL) + stall_cnt - h.stall_at));
                            head_seen = 1;
                        end
                        if (rsp_ready) begin
                            check("sb_is_write", 64'(rsp_is_write), 64'(h.rsp.is_write));
                            check("sb_err", 64'(rsp_err), 64'(h.rsp.err));
                            check("sb_rdata", 64'(rsp_rdata), 64'(h.rsp.rdata));
                            void'(exp_q.pop_front());
                            head_seen = 0;
                        end
                    end
                end
                if (hold_pend) begin
                    check("rsp_hold", 64'({rsp_valid, rsp_is_write, rsp_err, rsp_rdata}),
                          64'(held_out));
                end
                hold_pend = rsp_valid && !rsp_ready;
                held_out  = {rsp_valid, rsp_is_write, rsp_err, rsp_rdata};
                if (rsp_valid && !rsp_ready) stall_cnt++;
                if (req_valid && req_ready) begin
                    e.rsp.is_write = req_we;
                    e.rsp.err      = (int'(req_addr) >= int'(DEPTH));
                    e.rsp.rdata    = '0;
                    if (!e.rsp.err) begin
                        if (req_we) begin
                            w = model_mem[req_addr];
                            for (int b = 0; b < 4; b++) begin
                                if (req_wstrb[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
                            end
                            model_mem[req_addr] = w;
                        end else begin
                            e.rsp.rdata = model_mem[req_addr];
                        end
                    end
                    e.acc_cyc  = cyc;
                    e.stall_at = stall_cnt;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // ---------------- driver helpers (entered/left at posedge+1) ----------------
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] strb);
        bit accepted = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = strb;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge clk);
            if (req_ready) accepted = 1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!accepted) check("accept_timeout", 64'(accepted), 64'(1));
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [3:0] strb, output mem_rsp_t r);
        bit found = 0;
        r = '0;
        send(we, addr, wd, strb);
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clk);
            if (rsp_valid) begin
                r     = '{is_write: rsp_is_write, err: rsp_err, rdata: rsp_rdata};
                found = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!found) check("rsp_timeout", 64'(found), 64'(1));
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 60 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    wstrb;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[16];

    initial begin
        mem_rsp_t      r;
        mem_rsp_t      rr[2];
        int            rc[2];
        int            n;
        int            issued;
        int            stall_left;
        bit            first_stall;
        logic [DW-1:0] held_rd;
        logic [DW-1:0] got[$];
        logic          a0, a1;

        vecs[0]  = '{1'b1, 10'd5,    32'hDEADBEEF, 4'hF,    1'b0, 32'h0};
        vecs[1]  = '{1'b0, 10'd5,    32'h0,        4'h0,    1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 10'd7,    32'h11223344, 4'hF,    1'b0, 32'h0};
        vecs[3]  = '{1'b1, 10'd7,    32'hAABBCCDD, 4'b0101, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 10'd7,    32'h0,        4'h0,    1'b0, 32'h11BB33DD};
        vecs[5]  = '{1'b1, 10'd986,  32'hCAFEF00D, 4'hF,    1'b0, 32'h0};
        vecs[6]  = '{1'b1, 10'd1010, 32'h12345678, 4'hF,    1'b1, 32'h0};
        vecs[7]  = '{1'b0, 10'd1010, 32'h0,        4'h0,    1'b1, 32'h0};
        vecs[8]  = '{1'b0, 10'd986,  32'h0,        4'h0,    1'b0, 32'hCAFEF00D};
        vecs[9]  = '{1'b1, 10'd7,    32'hFFFFFFFF, 4'h0,    1'b0, 32'h0};
        vecs[10] = '{1'b0, 10'd7,    32'h0,        4'h0,    1'b0, 32'h11BB33DD};
        vecs[11] = '{1'b0, 10'd999,  32'h0,        4'h0,    1'b0, 32'h0};
        vecs[12] = '{1'b0, 10'd1000, 32'h0,        4'h0,    1'b1, 32'h0};
        vecs[13] = '{1'b1, 10'd999,  32'h01020304, 4'b1000, 1'b0, 32'h0};
        vecs[14] = '{1'b0, 10'd999,  32'h0,        4'h0,    1'b0, 32'h01000000};
        vecs[15] = '{1'b0, 10'd1023, 32'h0,        4'h0,    1'b1, 32'h0};

        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_is_write", 64'(rsp_is_write), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'(1));
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;

        // Bring the array to a known all-zero state, one write per cycle.
        for (int i = 0; i < int'(DEPTH); i++) send(1'b1, AW'(i), '0, 4'hF);
        wait_idle();

        // Table-driven directed vectors
        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
            check($sformatf("vec%0d_is_write", i), 64'(r.is_write), 64'(vecs[i].we));
            check($sformatf("vec%0d_err", i), 64'(r.err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_rdata", i), 64'(r.rdata), 64'(vecs[i].exp_rdata));
        end

        // Backpressure: 4 back-to-back reads, consumer stalls 3 cycles on the first response
        for (int i = 0; i < 4; i++) send(1'b1, AW'(i), DW'(32'hA0 + i), 4'hF);
        wait_idle();
        issued      = 0;
        stall_left  = 3;
        first_stall = 1;
        held_rd     = '0;
        got.delete();
        for (int c = 0; c < 40 && got.size() < 4; c++) begin
            req_valid = (issued < 4);
            req_we    = 1'b0;
            req_addr  = AW'(issued);
            rsp_ready = (stall_left == 0);
            @(negedge clk);
            if (rsp_valid && !rsp_ready) begin
                check("bp_req_ready", 64'(req_ready), 64'(0));
                if (!first_stall) check("bp_hold", 64'(rsp_rdata), 64'(held_rd));
                held_rd     = rsp_rdata;
                first_stall = 0;
                stall_left--;
            end else if (rsp_valid && rsp_ready) begin
                got.push_back(rsp_rdata);
            end
            if (req_valid && req_ready) issued++;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        check("bp_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < got.size(); i++) begin
            check($sformatf("bp_data%0d", i), 64'(got[i]), 64'(32'hA0 + i));
        end
        wait_idle();

        // Read-after-write, back to back
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'd9;
        req_wdata = 32'h5A5A5A5A;
        req_wstrb = 4'hF;
        @(negedge clk);
        a0 = req_ready;
        @(posedge clk);
        #1;
        req_we = 1'b0;
        @(negedge clk);
        a1 = req_ready;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("raw_accept_w", 64'(a0), 64'(1));
        check("raw_accept_r", 64'(a1), 64'(1));
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                rr[n] = '{is_write: rsp_is_write, err: rsp_err, rdata: rsp_rdata};
                rc[n] = c;
                n++;
            end
            @(posedge clk);
            #1;
        end
        check("raw_count", 64'(n), 64'(2));
        if (n == 2) begin
            check("raw_w_is_write", 64'(rr[0].is_write), 64'(1));
            check("raw_r_rdata", 64'(rr[1].rdata), 64'(32'h5A5A5A5A));
            check("raw_gap", 64'(rc[1] - rc[0]), 64'(1));
        end

        // Reset with two reads in flight; a request during reset is ignored
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'd5;
        @(negedge clk);
        a0 = req_ready;
        @(posedge clk);
        #1;
        req_addr = 10'd7;
        @(negedge clk);
        a1 = req_ready;
        @(posedge clk);
        #1;
        check("mid_accept0", 64'(a0), 64'(1));
        check("mid_accept1", 64'(a1), 64'(1));
        req_addr = 10'd9;
        rst_n    = 1'b1;
        @(negedge clk);
        check("mid_rst_req_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
            @(posedge clk);
            #1;
        end
        do_req(1'b0, 10'd5, '0, 4'h0, r);
        check("mid_rst_persist", 64'(r.rdata), 64'(32'hDEADBEEF));

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = AW'($urandom_range(0, 1023));
            req_wdata = $urandom;
            req_wstrb = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
